// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and default constants for the instruction fetch unit.
//   state_t       fetch FSM state (FETCH, WAIT, DRAIN, HOLD)
//   XLEN_DEF      default address/data width
//   RESET_PC_DEF  default PC after reset
//   PC_INC_DEF    default sequential PC step
package fetch_pkg;

    localparam int          XLEN_DEF     = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] PC_INC_DEF   = 32'd4;

    typedef enum logic [1:0] {
        FETCH = 2'd0,   // request outstanding on imem_req_valid
        WAIT  = 2'd1,   // request accepted, awaiting response
        DRAIN = 2'd2,   // swallow one response belonging to a stale path
        HOLD  = 2'd3    // instruction presented to decode
    } state_t;

endpackage

// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, issues one imem request per PC, and hands
// {pc, instr} to decode over valid/ready. Redirects may arrive in any state;
// responses for a stale path are discarded. At most one request outstanding.
//
// Ports:
//   clock, reset_n                 rising-edge clock, synchronous active-low reset
//   redirect_valid, redirect_pc    load a new fetch PC (priority over pc+step)
//   imem_req_valid/ready/addr      request channel (addr = current PC)
//   imem_rsp_valid/data            response channel, one beat per accepted request
//   out_valid/ready                handshake to decode
//   out_pc, out_instr, out_fault   delivered instruction and misalignment flag
//
// Build option FETCH_MISALIGN_TRAP_EN: a redirect to a target with nonzero
// low bits fetches nothing and instead delivers a faulting slot (out_fault=1,
// out_pc=target, out_instr=0). Without it the target's low two bits are
// cleared on load and out_fault stays 0.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN         = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_PC     = XLEN'(RESET_PC_DEF),
    parameter logic [XLEN-1:0] PC_INCREMENT = XLEN'(PC_INC_DEF)
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_instr,
    output logic            out_fault
);

`ifdef FETCH_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] out_pc_q, out_pc_d;
    logic [XLEN-1:0] out_instr_q, out_instr_d;
    logic            out_fault_q, out_fault_d;
    logic            fault_pend_q, fault_pend_d;
    logic            run_q;
    logic            req_fire;
    logic            redir_bad;
    logic [XLEN-1:0] redir_tgt;

    assign redir_bad = |redirect_pc[1:0];
    assign redir_tgt = TRAP_EN ? redirect_pc : (redirect_pc & ~XLEN'(3));

    // run_q keeps the request low for the whole reset window, including the
    // cycle in which reset_n is first seen high, without a comb input path.
    // A pending misalignment fault also suppresses the request.
    assign imem_req_valid = (state_q == FETCH) && run_q && !fault_pend_q;
    assign imem_req_addr  = pc_q;
    assign out_valid      = (state_q == HOLD);
    assign out_pc         = out_pc_q;
    assign out_instr      = out_instr_q;
    assign out_fault      = out_fault_q;

    assign req_fire = imem_req_valid && imem_req_ready;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        out_pc_d     = out_pc_q;
        out_instr_d  = out_instr_q;
        out_fault_d  = out_fault_q;
        fault_pend_d = fault_pend_q;

        case (state_q)
            FETCH: begin
                // A misaligned redirect is latched as fault_pend so that any
                // stale response is drained first; the fault slot is then
                // produced here instead of a memory request.
                if (fault_pend_q) begin
                    state_d      = HOLD;
                    out_pc_d     = pc_q;
                    out_instr_d  = '0;
                    out_fault_d  = 1'b1;
                    fault_pend_d = 1'b0;
                end else if (req_fire) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    state_d     = HOLD;
                    out_pc_d    = pc_q;
                    out_instr_d = imem_rsp_data;
                    out_fault_d = 1'b0;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = FETCH;
                    pc_d    = pc_q + PC_INCREMENT;
                end
            end
            DRAIN: begin
                if (imem_rsp_valid) state_d = FETCH;
            end
            default: state_d = FETCH;
        endcase

        // Redirect overrides the sequential path. Output registers are left
        // untouched so a dropped response never reaches out_instr.
        if (redirect_valid) begin
            pc_d         = redir_tgt;
            fault_pend_d = TRAP_EN && redir_bad;
            out_pc_d     = out_pc_q;
            out_instr_d  = out_instr_q;
            out_fault_d  = out_fault_q;
            case (state_q)
                FETCH:   state_d = req_fire ? DRAIN : FETCH;
                WAIT:    state_d = imem_rsp_valid ? FETCH : DRAIN;
                HOLD:    state_d = FETCH;
                DRAIN:   state_d = imem_rsp_valid ? FETCH : DRAIN;
                default: state_d = FETCH;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            out_pc_q     <= '0;
            out_instr_q  <= '0;
            out_fault_q  <= 1'b0;
            fault_pend_q <= 1'b0;
            run_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            out_pc_q     <= out_pc_d;
            out_instr_q  <= out_instr_d;
            out_fault_q  <= out_fault_d;
            fault_pend_q <= fault_pend_d;
            run_q        <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a bench-side memory responder, a
// PC-level reference model checked every cycle, and directed scenarios with
// literal expectations.
module tb_fetch_unit;

`ifdef FETCH_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif
    localparam logic [31:0] RST_PC = 32'h0;

    logic        clock = 1'b0;
    logic        reset_n, redirect_valid, imem_req_valid, imem_req_ready;
    logic        imem_rsp_valid, out_valid, out_ready, out_fault;
    logic [31:0] redirect_pc, imem_req_addr, imem_rsp_data, out_pc, out_instr;

    always #5 clock = ~clock;

    fetch_unit #(.XLEN(32), .RESET_PC(RST_PC), .PC_INCREMENT(32'd4)) dut (
        .clock(clock), .reset_n(reset_n),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr(out_instr), .out_fault(out_fault)
    );

    int errors = 0, checks = 0, cyc = 0;

    // reference model state
    logic [31:0] m_pc;
    bit          m_fault;
    // memory responder
    bit          pend_active = 0, pend_poison = 0, poison_next = 0;
    int          pend_cnt = 0, mem_lat = 1;
    logic [31:0] pend_addr;
    // previous-cycle snapshot
    bit          p_rst = 1, p_req_v = 0, p_req_r = 0, p_out_v = 0, p_out_r = 0, p_redir = 0;
    logic [31:0] p_addr, p_opc, p_oin;
    // logs
    logic [31:0] req_q[$];
    int          req_cyc[$];
    logic [31:0] del_pc[$];
    logic [31:0] del_in[$];
    int          del_cyc[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1357_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic compare();
        if (p_rst) begin
            chk("rst_req_valid", imem_req_valid, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_pc", out_pc, 0);
            chk("rst_out_instr", out_instr, 0);
            chk("rst_out_fault", out_fault, 0);
        end else begin
            if (imem_req_valid) chk("model_req_addr", imem_req_addr, m_pc);
            if (m_fault) chk("model_no_req_on_fault", imem_req_valid, 0);
            if (out_valid) begin
                chk("model_out_pc", out_pc, m_pc);
                chk("model_out_fault", out_fault, m_fault);
                chk("model_out_instr", out_instr, m_fault ? 32'h0 : mem_word(m_pc));
                chk("model_excl", imem_req_valid, 0);
            end
            if (p_req_v && !p_req_r && !p_redir) begin
                chk("req_held_valid", imem_req_valid, 1);
                chk("req_held_addr", imem_req_addr, p_addr);
            end
            if (p_out_v && !p_out_r && !p_redir) begin
                chk("out_held_valid", out_valid, 1);
                chk("out_held_pc", out_pc, p_opc);
                chk("out_held_instr", out_instr, p_oin);
            end
        end
    endtask

    task automatic predict();
        if (reset_n && imem_req_valid && imem_req_ready) begin
            chk("single_outstanding", pend_active, 0);
            req_q.push_back(imem_req_addr);
            req_cyc.push_back(cyc);
            pend_active = 1;
            pend_cnt    = mem_lat;
            pend_addr   = imem_req_addr;
            pend_poison = poison_next;
            poison_next = 0;
        end
        if (reset_n && out_valid && out_ready) begin
            del_pc.push_back(out_pc);
            del_in.push_back(out_instr);
            del_cyc.push_back(cyc);
        end
        p_rst = !reset_n; p_req_v = imem_req_valid; p_req_r = imem_req_ready;
        p_out_v = out_valid; p_out_r = out_ready; p_redir = redirect_valid;
        p_addr = imem_req_addr; p_opc = out_pc; p_oin = out_instr;
        if (!reset_n) begin
            m_pc = RST_PC; m_fault = 0;
        end else if (redirect_valid) begin
            m_pc    = TRAP ? redirect_pc : (redirect_pc & ~32'h3);
            m_fault = TRAP && (redirect_pc[1:0] != 2'b00);
        end else if (out_valid && out_ready) begin
            m_pc    = m_pc + 32'd4;
            m_fault = 0;
        end
    endtask

    // one clock cycle, entered and left at the falling edge
    task automatic step();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        if (pend_active) begin
            pend_cnt--;
            if (pend_cnt <= 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = pend_poison ? 32'hDEAD_BEEF : mem_word(pend_addr);
                pend_active    = 0;
            end
        end
        #1;
        compare();
        predict();
        @(posedge clock);
        @(negedge clock);
        cyc++;
    endtask

    task automatic run_until_req(input int maxc);
        int n0, k;
        n0 = req_q.size(); k = 0;
        while (req_q.size() == n0 && k < maxc) begin step(); k++; end
        chk("timeout_req", 32'(req_q.size() > n0), 1);
    endtask

    task automatic run_until_del(input int maxc);
        int n0, k;
        n0 = del_pc.size(); k = 0;
        while (del_pc.size() == n0 && k < maxc) begin step(); k++; end
        chk("timeout_del", 32'(del_pc.size() > n0), 1);
    endtask

    task automatic run_until_outv(input int maxc);
        int k;
        k = 0;
        while (!out_valid && k < maxc) begin step(); k++; end
        chk("timeout_outv", out_valid, 1);
    endtask

    initial begin
        int rel, n, nd, rc;
        reset_n = 0; redirect_valid = 0; redirect_pc = '0; imem_req_ready = 1;
        imem_rsp_valid = 0; imem_rsp_data = '0; out_ready = 1;
        m_pc = RST_PC; m_fault = 0;
        @(posedge clock); @(negedge clock);
        step(); step();

        // S1: streaming, zero-wait memory, decode always ready
        reset_n = 1; rel = cyc;
        req_q.delete(); req_cyc.delete(); del_pc.delete(); del_in.delete(); del_cyc.delete();
        repeat (10) step();
        chk("s1_nreq", 32'(req_q.size()), 3);
        chk("s1_ndel", 32'(del_pc.size()), 3);
        if (req_q.size() >= 3 && del_pc.size() >= 3) begin
            chk("s1_req0", req_q[0], 32'h0);
            chk("s1_req1", req_q[1], 32'h4);
            chk("s1_req2", req_q[2], 32'h8);
            chk("s1_first_req_cycle", 32'(req_cyc[0] - rel), 1);
            chk("s1_del0", del_pc[0], 32'h0);
            chk("s1_del1", del_pc[1], 32'h4);
            chk("s1_del2", del_pc[2], 32'h8);
            chk("s1_instr1", del_in[1], 32'h1357_0004);
            chk("s1_latency", 32'(del_cyc[0] - req_cyc[0]), 2);
            chk("s1_rate01", 32'(del_cyc[1] - del_cyc[0]), 3);
            chk("s1_rate12", 32'(del_cyc[2] - del_cyc[1]), 3);
        end

        // S2: memory back-pressure then decode stall
        reset_n = 0; step(); reset_n = 1;
        run_until_del(10);
        imem_req_ready = 0; n = req_q.size();
        repeat (4) begin
            chk("s2_req_valid", imem_req_valid, 1);
            chk("s2_req_addr", imem_req_addr, 32'h4);
            step();
        end
        chk("s2_no_dup", 32'(req_q.size()), 32'(n));
        imem_req_ready = 1; step();
        chk("s2_one_req", 32'(req_q.size()), 32'(n + 1));
        out_ready = 0;
        run_until_outv(5);
        repeat (5) begin
            chk("s2_hold_valid", out_valid, 1);
            chk("s2_hold_pc", out_pc, 32'h4);
            chk("s2_hold_instr", out_instr, 32'h1357_0004);
            step();
        end
        out_ready = 1; nd = del_pc.size(); step();
        chk("s2_ndel", 32'(del_pc.size()), 32'(nd + 1));
        if (del_pc.size() > nd) chk("s2_del_pc", del_pc[nd], 32'h4);

        // S3: redirect while waiting; stale response arrives two cycles later
        mem_lat = 3; poison_next = 1;
        run_until_req(10);
        redirect_valid = 1; redirect_pc = 32'h100; rc = cyc; step();
        redirect_valid = 0; mem_lat = 1; n = req_q.size();
        for (int k = 0; k < 10 && req_q.size() == n; k++) begin
            chk("s3_no_stale", 32'(out_instr == 32'hDEAD_BEEF), 0);
            step();
        end
        chk("s3_nreq", 32'(req_q.size()), 32'(n + 1));
        if (req_q.size() > n) begin
            chk("s3_req_addr", req_q[n], 32'h100);
            chk("s3_req_after_drain", 32'(req_cyc[n] - rc), 3);
        end
        run_until_del(10);
        chk("s3_del_pc", del_pc[$], 32'h100);
        chk("s3_del_instr", del_in[$], 32'h1357_0100);

        // S4: redirect in HOLD with decode accepting the same cycle
        out_ready = 0;
        run_until_outv(10);
        nd = del_pc.size(); n = req_q.size();
        redirect_valid = 1; redirect_pc = 32'h200; out_ready = 1; step();
        redirect_valid = 0;
        chk("s4_delivered_once", 32'(del_pc.size()), 32'(nd + 1));
        if (del_pc.size() > nd) chk("s4_del_pc", del_pc[nd], 32'h104);
        run_until_req(10);
        if (req_q.size() > n) chk("s4_req_addr", req_q[n], 32'h200);
        run_until_del(10);
        if (del_pc.size() > nd + 1) chk("s4_next_del", del_pc[nd + 1], 32'h200);

        // S5: PC wrap-around
        redirect_valid = 1; redirect_pc = 32'hFFFF_FFFC; step();
        redirect_valid = 0;
        run_until_del(10);
        chk("s5_del_pc", del_pc[$], 32'hFFFF_FFFC);
        n = req_q.size();
        run_until_req(10);
        if (req_q.size() > n) chk("s5_wrap_addr", req_q[n], 32'h0);

        // S6: reset while a request is outstanding
        mem_lat = 3; poison_next = 1;
        run_until_req(10);
        reset_n = 0; step();
        reset_n = 1; mem_lat = 1; n = req_q.size();
        run_until_req(10);
        if (req_q.size() > n) chk("s6_req_addr", req_q[n], RST_PC);
        run_until_del(10);
        chk("s6_del_pc", del_pc[$], 32'h0);
        chk("s6_del_instr", del_in[$], 32'h1357_0000);

        // S7: misaligned redirect target
        imem_req_ready = 0; step();
        n = req_q.size();
        redirect_valid = 1; redirect_pc = 32'h102; step();
        redirect_valid = 0; imem_req_ready = 1;
`ifdef FETCH_MISALIGN_TRAP_EN
        out_ready = 0;
        run_until_outv(5);
        chk("s7_fault", out_fault, 1);
        chk("s7_pc", out_pc, 32'h102);
        chk("s7_instr", out_instr, 32'h0);
        chk("s7_no_req", 32'(req_q.size()), 32'(n));
        out_ready = 1; step();
        run_until_req(10);
        if (req_q.size() > n) chk("s7_next_addr", req_q[n], 32'h106);
`else
        run_until_req(10);
        if (req_q.size() > n) chk("s7_aligned_addr", req_q[n], 32'h100);
        chk("s7_fault_tied", out_fault, 0);
`endif
        repeat (4) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
